lsu: RTL

- Load/store unit directly downstream of the ALU.
- Consumes ALUResult as the effective byte address for RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a word-addressed data memory through a req/ack handshake and returns a sign- or zero-extended load value to writeback.
- Stalls the core while an access is outstanding.

---
 rtl/lsu_pkg.sv | 72 +++++++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/lsu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   - lsu_state_t   : FSM state encoding (IDLE, ACCESS, RESP, ERR)
//   - F3_*          : RISC-V funct3 width/sign selectors for loads and stores
//   - BE_ALL        : full-word byte enable
//   - lsu_is_legal  : op/funct3 legality check
//   - lsu_is_aligned: natural-alignment check for the access width
//   - lsu_store_be  : byte-enable pattern for a store of a given width
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_ALL = 4'b1111;

    // A request is legal when it is exactly one of load/store and its funct3
    // names a width that op supports (stores have no unsigned variants).
    function automatic logic lsu_is_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (wr) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else if (rd) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic lsu_is_aligned(input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic ok;
        ok = 1'b1;
        case (f3)
            F3_H, F3_HU: ok = ~lo[0];
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by a store of width f3 at byte offset lo.
    function automatic logic [3:0] lsu_store_be(input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [3:0] be;
        be = BE_ALL;
        case (f3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = BE_ALL;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data formatter. Picks the addressed byte or halfword out
// of the memory word and sign- or zero-extends it; words pass through.
// Ports:
//   i_rdata   : raw word returned by data memory
//   i_addr_lo : byte offset within the word (address bits [1:0])
//   i_funct3  : load width/sign selector (LB/LH/LW/LBU/LHU)
//   o_data    : extended value for writeback
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_addr_lo,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane = offset*8, half lane = offset[1]*16.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_H:    o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
// Load/store unit sitting after the ALU. Takes the ALU result as a byte
// address, runs one access at a time against a word-addressed data memory
// over a req/ack handshake, and returns extended load data to writeback.
// The upstream pipeline is stalled for as long as an access is in flight.
//
// Optional build macro: LSU_TIMEOUT_EN
//   When defined, an ack watchdog aborts an access after TIMEOUT_CYCLES
//   cycles in ACCESS and reports a fault. When undefined, ACCESS waits for
//   ack indefinitely.
//
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-low reset
//   req_valid         : memory op presented this cycle
//   mem_read/mem_write: op is a load / store
//   funct3            : width/sign selector
//   ALUResult         : effective byte address
//   wr_data           : store data (rs2)
//   req_ready         : high only while idle
//   stall             : freeze upstream pipeline
//   done              : one-cycle completion pulse
//   rd_data           : extended load result, valid with done on loads
//   fault             : one-cycle pulse on misaligned/illegal/timeout
//   dmem_req/we/addr/be/wdata : memory request, held until dmem_ack
//   dmem_ack, dmem_rdata      : memory completion and read word
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fault,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t            r_state;
    logic                  r_req_ready;
    logic                  r_done;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [ADDR_WIDTH-1:0] r_dmem_addr;
    logic [3:0]            r_dmem_be;
    logic [DATA_WIDTH-1:0] r_dmem_wdata;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_funct3;
    logic                  r_is_load;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      r_cnt;
`endif

    logic                  w_req;
    logic                  w_legal;
    logic                  w_aligned;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_value;
    logic                  w_unused_addr_hi;

    // Address bits above the memory's reach simply wrap.
    assign w_unused_addr_hi = ^ALUResult[DATA_WIDTH-1:ADDR_WIDTH+2];

    assign w_req     = req_valid & (mem_read | mem_write);
    assign w_legal   = lsu_is_legal(mem_read, mem_write, funct3);
    assign w_aligned = lsu_is_aligned(funct3, ALUResult[1:0]);
    assign w_be      = mem_write ? lsu_store_be(funct3, ALUResult[1:0]) : BE_ALL;

    // Replicate narrow store data across every lane so the byte enables alone
    // pick the destination bytes.
    always_comb begin
        w_wdata = '0;
        if (mem_write) begin
            case (funct3)
                F3_B:    w_wdata = {(DATA_WIDTH/8){wr_data[7:0]}};
                F3_H:    w_wdata = {(DATA_WIDTH/16){wr_data[15:0]}};
                default: w_wdata = wr_data;
            endcase
        end
    end

    // Formats the returned word using the offset/width latched at accept.
    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_value)
    );

    // Stall is combinational so the op presented in IDLE freezes the pipe in
    // the same cycle it is accepted.
    assign stall = (r_state != ST_IDLE) | (w_req & (r_state == ST_IDLE));

    // Control FSM. All handshake/status outputs are registered here; the
    // memory request fields are captured at accept and held through ACCESS.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_rd_data    <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_addr_lo    <= '0;
            r_funct3     <= '0;
            r_is_load    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_req_ready <= 1'b0;
                        r_addr_lo   <= ALUResult[1:0];
                        r_funct3    <= funct3;
                        r_is_load   <= mem_read & ~mem_write;
                        if (w_legal && w_aligned) begin
                            r_state      <= ST_ACCESS;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= mem_write;
                            r_dmem_addr  <= ALUResult[ADDR_WIDTH+1:2];
                            r_dmem_be    <= w_be;
                            r_dmem_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                            r_cnt        <= '0;
`endif
                        end else begin
                            // Rejected ops never touch memory.
                            r_state <= ST_ERR;
                            r_fault <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_is_load) begin
                            r_rd_data <= w_load_value;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Memory never answered: abandon the request.
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_fault    <= 1'b1;
                        r_state    <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP, ST_ERR: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign done       = r_done;
    assign fault      = r_fault;
    assign rd_data    = r_rd_data;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_be    = r_dmem_be;
    assign dmem_wdata = r_dmem_wdata;

endmodule
